id_ex_skid: RTL and testbench
=============================

# id_ex_skid

Parametrised ID/EX pipeline register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and NOP bubble injection. It sits between the decode stage and the execute stage. It carries the decoded ALU op, ALU select, two operands, the destination register address and the write enable. It lets EX back-pressure ID without a combinational ready path through the stage.

## Interface
- AOP_W, 8, ALU op width
- ASEL_W, 3, ALU select width
- DATA_W, 32, operand width
- RA_W, 5, register address width
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard every held and incoming instruction this cycle
- id_valid  in  1  ID presents a decoded instruction
- id_ready  out  1  stage can accept; equals NOT skid_valid (registered)
- id_aluop  in  AOP_W  decoded ALU op
- id_alusel  in  ASEL_W  decoded ALU select
- id_reg1, id_reg2  in  DATA_W each  operands
- id_wd  in  RA_W  destination register
- id_wreg  in  1  write enable
- ex_valid  out  1  main entry holds an instruction
- ex_ready  in  1  EX consumes the main entry this cycle
- ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg  out  as inputs  main entry fields; forced to NOP values when ex_valid=0
- stall_cnt  out  16  back-pressure cycle count (only with PIPE_STALL_CNT_EN)

## Operation
- Storage is a main entry (M) and a skid entry (S), each holding all six fields plus a valid bit.
- Accept occurs when id_valid & id_ready. Drain occurs when ex_valid & ex_ready.
- States are EMPTY (M and S invalid), BUSY (M valid only) and FULL (M and S valid).
- EMPTY: accept loads M and goes to BUSY.
- BUSY, accept and drain: M is replaced by the input; the state stays BUSY.
- BUSY, drain only: go to EMPTY.
- BUSY, accept only: the input goes to S; go to FULL.
- BUSY, neither: hold.
- FULL: id_ready=0, so there is no accept. Drain moves S into M and goes to BUSY. Otherwise hold.
- Order is preserved: M always holds the older instruction.
- flush=1: M and S are invalidated next cycle and the state goes to EMPTY. A same-cycle accept is dropped. A same-cycle drain still counts as consumed by EX.
- NOP values are aluop=0 (EXE_NOP_OP), alusel=0 (EXE_RES_NOP), reg1=reg2=0, wd=0, wreg=0.
- Outputs show NOP values whenever ex_valid=0, so an invalid entry never asserts a register write.
- Invalidating an entry clears its stored payload to NOP values, not just its valid bit.
- While held, the payload is stable: ex_* do not change while ex_valid & !ex_ready.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is on ex_* with ex_valid=1 after edge N.
- Sustained throughput is 1 instruction per cycle when ex_ready=1.
- id_ready is a flop output with no combinational path from ex_ready.
- Reset values: ex_valid=0, id_ready=1, all ex_* at NOP values, S cleared, stall_cnt=0, state EMPTY.
- Reset mid-operation discards both entries regardless of flush or handshake inputs.
- rst has priority over flush, and flush has priority over accept and drain.

## Configuration
- PIPE_STALL_CNT_EN defined: stall_cnt increments each cycle with ex_valid & !ex_ready.
  - It saturates at 16'hFFFF.
  - It is cleared only by rst; flush does not clear it.
- PIPE_STALL_CNT_EN undefined: the stall_cnt port and its counter are absent.

## Test plan
- Reset, then idle: ex_valid=0, ex_aluop=0, ex_wreg=0, id_ready=1.
- Streaming: ex_ready=1, three instructions on back-to-back cycles (aluop 8'h25, 8'h26, 8'h27) -> appear on ex_aluop in order, each one cycle after accept, with no bubbles.
- Back-pressure:
  - Setup: ex_ready=0; accept A (reg1=32'h1111) and then B (reg1=32'h2222).
  - While stalled: id_ready=0 after B; ex_reg1 is held at 32'h1111.
  - Release: raising ex_ready outputs A, then B the next cycle, and id_ready returns to 1.
- Flush while FULL with a same-cycle id_valid -> next cycle ex_valid=0, id_ready=1, ex_wreg=0, and the incoming instruction is never output.
- Reset asserted while FULL with ex_ready=1 -> next cycle all outputs are at their reset values.
- With PIPE_STALL_CNT_EN: hold ex_valid=1, ex_ready=0 for 5 cycles -> stall_cnt=5; a later flush leaves it at 5.

Source files
------------

// File: rtl/id_ex_skid.sv
// id_ex_skid: ID/EX pipeline register with a valid/ready handshake and a
// two-entry skid buffer.
//
// The main entry (M) feeds EX. The skid entry (S) catches the one extra
// instruction that ID may send in the cycle after EX stalls, because
// id_ready is a flop. That flop keeps ex_ready off any combinational path
// back into ID.
//
// flush empties both entries. Any slot that is not valid has its payload
// zeroed, which is the NOP encoding. An invalid slot therefore never shows
// a register write on its outputs.
//
// Optional feature: define PIPE_STALL_CNT_EN to add the stall_cnt port.
// stall_cnt is a saturating count of the cycles in which EX holds off a
// valid main entry.
module id_ex_skid #(
  parameter int AOP_W  = 8,
  parameter int ASEL_W = 3,
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [AOP_W-1:0]  id_aluop,
  input  logic [ASEL_W-1:0] id_alusel,
  input  logic [DATA_W-1:0] id_reg1,
  input  logic [DATA_W-1:0] id_reg2,
  input  logic [RA_W-1:0]   id_wd,
  input  logic              id_wreg,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [AOP_W-1:0]  ex_aluop,
  output logic [ASEL_W-1:0] ex_alusel,
  output logic [DATA_W-1:0] ex_reg1,
  output logic [DATA_W-1:0] ex_reg2,
  output logic [RA_W-1:0]   ex_wd,
  output logic              ex_wreg
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef struct packed {
    logic [AOP_W-1:0]  aluop;
    logic [ASEL_W-1:0] alusel;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [RA_W-1:0]   wd;
    logic              wreg;
  } payload_t;

  // An all-zero payload is the NOP encoding (EXE_NOP_OP, EXE_RES_NOP, no write).
  localparam payload_t NOP = '0;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t   state;
  payload_t m_q, s_q, in_p;
  logic     m_valid, s_valid;
  logic     accept, drain;

  assign in_p = '{aluop: id_aluop, alusel: id_alusel, reg1: id_reg1,
                  reg2: id_reg2, wd: id_wd, wreg: id_wreg};

  assign accept = id_valid & id_ready;
  assign drain  = m_valid & ex_ready;

  // Handshake FSM. It updates both entries, their valid bits and the id_ready flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      m_q      <= NOP;
      s_q      <= NOP;
      m_valid  <= 1'b0;
      s_valid  <= 1'b0;
      id_ready <= 1'b1;
    end else if (flush) begin
      // A same-cycle accept is dropped. A same-cycle drain was already
      // taken by EX, so nothing remains to keep.
      state    <= EMPTY;
      m_q      <= NOP;
      s_q      <= NOP;
      m_valid  <= 1'b0;
      s_valid  <= 1'b0;
      id_ready <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            m_q     <= in_p;
            m_valid <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (accept && drain) begin
            m_q <= in_p;
          end else if (drain) begin
            m_q     <= NOP;
            m_valid <= 1'b0;
            state   <= EMPTY;
          end else if (accept) begin
            // EX is stalled. Park the younger instruction in S and close the input.
            s_q      <= in_p;
            s_valid  <= 1'b1;
            id_ready <= 1'b0;
            state    <= FULL;
          end
        end
        FULL: begin
          // id_ready is low in this state, so only a drain can happen.
          if (drain) begin
            m_q      <= s_q;
            s_q      <= NOP;
            s_valid  <= 1'b0;
            id_ready <= 1'b1;
            state    <= BUSY;
          end
        end
        default: begin
          state    <= EMPTY;
          m_q      <= NOP;
          s_q      <= NOP;
          m_valid  <= 1'b0;
          s_valid  <= 1'b0;
          id_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ex_valid = m_valid;

  // Gate the payload with the valid bit so that an invalid entry always shows NOP.
  // This holds even though invalidation already zeroes the stored payload.
  assign ex_aluop  = m_valid ? m_q.aluop  : NOP.aluop;
  assign ex_alusel = m_valid ? m_q.alusel : NOP.alusel;
  assign ex_reg1   = m_valid ? m_q.reg1   : NOP.reg1;
  assign ex_reg2   = m_valid ? m_q.reg2   : NOP.reg2;
  assign ex_wd     = m_valid ? m_q.wd     : NOP.wd;
  assign ex_wreg   = m_valid ? m_q.wreg   : NOP.wreg;

`ifdef PIPE_STALL_CNT_EN
  // Saturating count of back-pressure cycles. Only rst clears it; flush does not.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (m_valid && !ex_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_id_ex_skid.sv
// Directed bench for id_ex_skid.
//
// The vector table drives one cycle per record. Each record lists the
// inputs and the outputs expected after the next rising edge.
// Hand-written sequences follow the table. They cover payload stability
// under a held stall and the optional stall counter.
//
// Stimulus side fields are derived from each instruction's aluop and reg1:
//   alusel = aluop[2:0], wd = aluop[4:0], reg2 = ~reg1.
module tb_id_ex_skid;

  logic        clk = 1'b0;
  logic        rst, flush, id_valid, id_ready, id_wreg;
  logic [7:0]  id_aluop;
  logic [2:0]  id_alusel;
  logic [31:0] id_reg1, id_reg2;
  logic [4:0]  id_wd;
  logic        ex_valid, ex_ready, ex_wreg;
  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [31:0] ex_reg1, ex_reg2;
  logic [4:0]  ex_wd;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  id_ex_skid dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_aluop(id_aluop), .id_alusel(id_alusel),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
    .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, iv;
    logic [7:0]  op;
    logic [31:0] r1;
    logic        w, er;
    logic        ev, ir;
    logic [7:0]  eop;
    logic [31:0] er1;
    logic        ew;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs #1 after an edge, then sample #1 after the next edge.
  task automatic step(input logic r, input logic f, input logic iv, input logic [7:0] op,
                      input logic [31:0] r1, input logic w, input logic er);
    rst = r; flush = f; id_valid = iv; id_aluop = op; id_alusel = op[2:0];
    id_reg1 = r1; id_reg2 = ~r1; id_wd = op[4:0]; id_wreg = w; ex_ready = er;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic ir,
                            input logic [7:0] eop, input logic [31:0] er1, input logic ew);
    logic [7:0] op_v;
    op_v = eop;
    check({tag, " ex_valid"}, 32'(ex_valid), 32'(ev));
    check({tag, " id_ready"}, 32'(id_ready), 32'(ir));
    check({tag, " ex_aluop"}, 32'(ex_aluop), 32'(eop));
    check({tag, " ex_reg1"},  ex_reg1, er1);
    check({tag, " ex_wreg"},  32'(ex_wreg), 32'(ew));
    check({tag, " ex_alusel"}, 32'(ex_alusel), ev ? 32'(op_v[2:0]) : 32'd0);
    check({tag, " ex_wd"},     32'(ex_wd),     ev ? 32'(op_v[4:0]) : 32'd0);
    check({tag, " ex_reg2"},   ex_reg2,        ev ? ~er1 : 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0; id_aluop = '0; id_alusel = '0;
    id_reg1 = '0; id_reg2 = '0; id_wd = '0; id_wreg = 1'b0; ex_ready = 1'b0;

    //            rst flush iv  op     r1            w  er   ev ir  eop    er1           ew
    // reset, then idle
    tbl[0]  = '{1, 0, 0, 8'h00, 32'h0,        0, 0,  0, 1, 8'h00, 32'h0,        0};
    tbl[1]  = '{0, 0, 0, 8'h00, 32'h0,        0, 1,  0, 1, 8'h00, 32'h0,        0};
    // streaming with no bubbles; the 8'h26 instruction carries wreg=0
    tbl[2]  = '{0, 0, 1, 8'h25, 32'h25,       1, 1,  1, 1, 8'h25, 32'h25,       1};
    tbl[3]  = '{0, 0, 1, 8'h26, 32'h26,       0, 1,  1, 1, 8'h26, 32'h26,       0};
    tbl[4]  = '{0, 0, 1, 8'h27, 32'h27,       1, 1,  1, 1, 8'h27, 32'h27,       1};
    tbl[5]  = '{0, 0, 0, 8'h00, 32'h0,        0, 1,  0, 1, 8'h00, 32'h0,        0};
    // back-pressure: A then B while stalled; C is offered while FULL and ignored
    tbl[6]  = '{0, 0, 1, 8'hA1, 32'h1111,     1, 0,  1, 1, 8'hA1, 32'h1111,     1};
    tbl[7]  = '{0, 0, 1, 8'hB2, 32'h2222,     1, 0,  1, 0, 8'hA1, 32'h1111,     1};
    tbl[8]  = '{0, 0, 1, 8'hC3, 32'h3333,     1, 0,  1, 0, 8'hA1, 32'h1111,     1};
    tbl[9]  = '{0, 0, 0, 8'h00, 32'h0,        0, 1,  1, 1, 8'hB2, 32'h2222,     1};
    tbl[10] = '{0, 0, 0, 8'h00, 32'h0,        0, 1,  0, 1, 8'h00, 32'h0,        0};
    // flush while FULL with a same-cycle id_valid
    tbl[11] = '{0, 0, 1, 8'h11, 32'h11,       1, 0,  1, 1, 8'h11, 32'h11,       1};
    tbl[12] = '{0, 0, 1, 8'h12, 32'h12,       1, 0,  1, 0, 8'h11, 32'h11,       1};
    tbl[13] = '{0, 1, 1, 8'h13, 32'h13,       1, 0,  0, 1, 8'h00, 32'h0,        0};
    tbl[14] = '{0, 0, 0, 8'h00, 32'h0,        0, 1,  0, 1, 8'h00, 32'h0,        0};
    // flush while BUSY with a same-cycle accept and drain
    tbl[15] = '{0, 0, 1, 8'h14, 32'h14,       1, 1,  1, 1, 8'h14, 32'h14,       1};
    tbl[16] = '{0, 1, 1, 8'h15, 32'h15,       1, 1,  0, 1, 8'h00, 32'h0,        0};
    tbl[17] = '{0, 0, 0, 8'h00, 32'h0,        0, 1,  0, 1, 8'h00, 32'h0,        0};
    // reset while FULL with ex_ready=1 and id_valid high
    tbl[18] = '{0, 0, 1, 8'h21, 32'h21,       1, 0,  1, 1, 8'h21, 32'h21,       1};
    tbl[19] = '{0, 0, 1, 8'h22, 32'h22,       1, 0,  1, 0, 8'h21, 32'h21,       1};
    tbl[20] = '{1, 0, 1, 8'h23, 32'h23,       1, 1,  0, 1, 8'h00, 32'h0,        0};
    tbl[21] = '{0, 0, 0, 8'h00, 32'h0,        0, 1,  0, 1, 8'h00, 32'h0,        0};

    @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++) begin
      step(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].op, tbl[i].r1, tbl[i].w, tbl[i].er);
      check_outs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ir, tbl[i].eop, tbl[i].er1, tbl[i].ew);
    end

    // Held payload stays put while the ID inputs keep changing during a stall.
    step(1, 0, 0, 8'h00, 32'h0, 0, 0);
    step(0, 0, 1, 8'h5A, 32'hAAAA_5555, 1, 0);
    check_outs("hold0", 1, 1, 8'h5A, 32'hAAAA_5555, 1);
    step(0, 0, 1, 8'h6B, 32'hBBBB_0000, 0, 0);
    check_outs("hold1", 1, 0, 8'h5A, 32'hAAAA_5555, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 8'(8'h70 + k), 32'(k), 1, 0);
      check_outs($sformatf("hold%0d", k + 2), 1, 0, 8'h5A, 32'hAAAA_5555, 1);
    end
    // Release the stall: the older instruction 5A was already seen. S (6B, wreg=0) moves up.
    step(0, 0, 0, 8'h00, 32'h0, 0, 1);
    check_outs("rel0", 1, 1, 8'h6B, 32'hBBBB_0000, 0);
    step(0, 0, 0, 8'h00, 32'h0, 0, 1);
    check_outs("rel1", 0, 1, 8'h00, 32'h0, 0);

`ifdef PIPE_STALL_CNT_EN
    step(1, 0, 0, 8'h00, 32'h0, 0, 0);
    check("stall_cnt reset", 32'(stall_cnt), 32'd0);
    step(0, 0, 1, 8'h31, 32'h31, 1, 0);
    check("stall_cnt after accept", 32'(stall_cnt), 32'd0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 8'h00, 32'h0, 0, 0);
    check("stall_cnt five", 32'(stall_cnt), 32'd5);
    // Flush with ex_ready=1. This cycle is not a stall, and flush must not clear the count.
    step(0, 1, 0, 8'h00, 32'h0, 0, 1);
    check("stall_cnt after flush", 32'(stall_cnt), 32'd5);
    step(0, 0, 0, 8'h00, 32'h0, 0, 0);
    check("stall_cnt idle", 32'(stall_cnt), 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
